// File: rtl/lsp_get_tdist_pkg.sv
// Shared types, constants and ITU 16-bit basic ops for lsp_get_tdist.
// Optional RAM write-back of the result: LSP_GET_TDIST_MEMWRITE_EN.
package lsp_get_tdist_pkg;

  localparam int M       = 10;
  localparam int SHL_AMT = 4;

  localparam logic signed [31:0] MAX_32 = 32'sh7FFFFFFF;
  localparam logic signed [31:0] MIN_32 = 32'sh80000000;
  localparam logic signed [15:0] MAX_16 = 16'sh7FFF;
  localparam logic signed [15:0] MIN_16 = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE,
    RD_BUF,
    RD_RBUF,
    RD_FG,
    RD_WEGT,
    ACC,
    DONE
  } state_t;

  function automatic logic signed [15:0] sat16(
    input logic signed [32:0] v
  );
    if (v > 33'sd32767)
      return MAX_16;
    else if (v < -33'sd32768)
      return MIN_16;
    else
      return v[15:0];
  endfunction

  function automatic logic signed [31:0] sat32(
    input logic signed [47:0] v
  );
    if (v > 48'sh7FFFFFFF)
      return MAX_32;
    else if (v < -48'sh80000000)
      return MIN_32;
    else
      return v[31:0];
  endfunction

  function automatic logic signed [15:0] sub16(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    logic signed [32:0] d;
    d = 33'(a) - 33'(b);
    return sat16(d);
  endfunction

  // Q15 product; only -32768*-32768 overflows
  function automatic logic signed [15:0] mult16(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    logic signed [32:0] p;
    p = 33'(a) * 33'(b);
    return sat16(p >>> 15);
  endfunction

endpackage

// File: rtl/lsp_get_tdist_if.sv
// Control and RAM bus bundle for lsp_get_tdist.
// slave = distortion engine, master = sequencing controller / RAM side.
interface lsp_get_tdist_if;

  logic        start;
  logic [10:0] wegtAddr;
  logic [10:0] bufAddr;
  logic [10:0] rbufAddr;
  logic [10:0] fgSumAddr;
  logic [10:0] tdistAddr;
  logic [31:0] memIn;
  logic [10:0] memReadAddr;
  logic        memWriteEn;
  logic [10:0] memWriteAddr;
  logic [31:0] memOut;
  logic [31:0] L_tdist;
  logic        done;

  modport slave (
    input  start,
    input  wegtAddr,
    input  bufAddr,
    input  rbufAddr,
    input  fgSumAddr,
    input  tdistAddr,
    input  memIn,
    output memReadAddr,
    output memWriteEn,
    output memWriteAddr,
    output memOut,
    output L_tdist,
    output done
  );

  modport master (
    output start,
    output wegtAddr,
    output bufAddr,
    output rbufAddr,
    output fgSumAddr,
    output tdistAddr,
    output memIn,
    input  memReadAddr,
    input  memWriteEn,
    input  memWriteAddr,
    input  memOut,
    input  L_tdist,
    input  done
  );

endinterface

// File: rtl/lsp_tdist_mac.sv
// ACC datapath: L_mult, L_shl, extract_h and L_mac with saturation.
module lsp_tdist_mac
  import lsp_get_tdist_pkg::*;
(
  input  logic signed [15:0] wegt,
  input  logic signed [15:0] tmp,
  input  logic signed [31:0] lTdist,
  output logic signed [15:0] tmp2,
  output logic signed [31:0] lTdistNext
);

  logic signed [47:0] lAccWide;
  logic signed [47:0] lShlWide;
  logic signed [47:0] lProdWide;
  logic signed [47:0] lMacWide;
  logic signed [31:0] lAcc;
  logic signed [31:0] lShl;
  logic signed [31:0] lProd;

  always_comb begin
    lAccWide   = 48'(wegt) * 48'(tmp) * 48'sd2;
    lAcc       = sat32(lAccWide);
    lShlWide   = 48'(lAcc) <<< SHL_AMT;
    lShl       = sat32(lShlWide);
    tmp2       = lShl[31:16];
    lProdWide  = 48'(tmp2) * 48'(tmp) * 48'sd2;
    lProd      = sat32(lProdWide);
    lMacWide   = 48'(lTdist) + 48'(lProd);
    lTdistNext = sat32(lMacWide);
  end

endmodule

// File: rtl/lsp_get_tdist.sv
// G.729 Lsp_get_tdist: weighted distortion of one LSP candidate from RAM.
// Define LSP_GET_TDIST_MEMWRITE_EN to also write L_tdist to tdistAddr.
module lsp_get_tdist
  import lsp_get_tdist_pkg::*;
(
  input logic            clk,
  input logic            reset,
  lsp_get_tdist_if.slave bus
);

  localparam logic [3:0] JLAST = 4'(M - 1);

  state_t state;
  state_t stateNext;

  logic        [3:0]  j;
  logic signed [15:0] bufReg;
  logic signed [15:0] diff;
  logic signed [15:0] tmp;
  logic signed [31:0] lTdist;
  logic signed [31:0] lTdistNext;
  logic signed [15:0] tmp2;
  logic signed [15:0] memData;

  assign memData     = signed'(bus.memIn[15:0]);
  assign bus.L_tdist = lTdist;

  lsp_tdist_mac u_mac (
    .wegt       (memData),
    .tmp        (tmp),
    .lTdist     (lTdist),
    .tmp2       (tmp2),
    .lTdistNext (lTdistNext)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.start) stateNext = RD_BUF;
      RD_BUF:  stateNext = RD_RBUF;
      RD_RBUF: stateNext = RD_FG;
      RD_FG:   stateNext = RD_WEGT;
      RD_WEGT: stateNext = ACC;
      ACC:     stateNext = (j == JLAST) ? DONE : RD_BUF;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // memIn carries the element addressed in the previous state
  always_ff @(posedge clk) begin
    if (reset) begin
      j      <= '0;
      bufReg <= '0;
      diff   <= '0;
      tmp    <= '0;
      lTdist <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            lTdist <= '0;
            j      <= '0;
          end
        end
        RD_RBUF: bufReg <= memData;
        RD_FG:   diff   <= sub16(bufReg, memData);
        RD_WEGT: tmp    <= mult16(diff, memData);
        ACC: begin
          lTdist <= lTdistNext;
          if (j != JLAST)
            j <= j + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.memReadAddr  = '0;
    bus.memWriteEn   = 1'b0;
    bus.memWriteAddr = '0;
    bus.memOut       = '0;
    bus.done         = 1'b0;
    unique case (state)
      RD_BUF:  bus.memReadAddr = {bus.bufAddr[10:4], j};
      RD_RBUF: bus.memReadAddr = {bus.rbufAddr[10:4], j};
      RD_FG:   bus.memReadAddr = {bus.fgSumAddr[10:4], j};
      RD_WEGT: bus.memReadAddr = {bus.wegtAddr[10:4], j};
      DONE: begin
        bus.done = 1'b1;
`ifdef LSP_GET_TDIST_MEMWRITE_EN
        bus.memWriteEn   = 1'b1;
        bus.memWriteAddr = bus.tdistAddr;
        bus.memOut       = lTdist;
`endif
      end
      default: ;
    endcase
  end

  logic unusedBits;
`ifdef LSP_GET_TDIST_MEMWRITE_EN
  assign unusedBits = ^{bus.memIn[31:16], bus.wegtAddr[3:0],
                        bus.bufAddr[3:0], bus.rbufAddr[3:0],
                        bus.fgSumAddr[3:0], tmp2};
`else
  assign unusedBits = ^{bus.memIn[31:16], bus.wegtAddr[3:0],
                        bus.bufAddr[3:0], bus.rbufAddr[3:0],
                        bus.fgSumAddr[3:0], tmp2,
                        bus.tdistAddr};
`endif

endmodule

// File: tb/tb_lsp_get_tdist.sv
// Scoreboard bench for lsp_get_tdist: expected L_tdist and read
// addresses are queued at start and popped as the DUT produces them.
module tb_lsp_get_tdist;

  localparam int M   = 10;
  localparam int LAT = 5 * M + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsp_get_tdist_if bus ();

  lsp_get_tdist dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:2047];
  always @(posedge clk) bus.memIn <= mem[bus.memReadAddr];

  int errors = 0;
  int checks = 0;

  logic [31:0] expQ [$];
  logic [10:0] addrQ [$];

  int bv [16];
  int rv [16];
  int fv [16];
  int wv [16];

  logic [10:0] bB = 11'h100;
  logic [10:0] rB = 11'h200;
  logic [10:0] fB = 11'h300;
  logic [10:0] wB = 11'h400;
  logic [10:0] tA = 11'h7F0;

  function automatic longint s32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic longint s16(input longint v);
    if (v > 64'sd32767) return 64'sd32767;
    if (v < -64'sd32768) return -64'sd32768;
    return v;
  endfunction

  function automatic logic [31:0] model();
    longint acc, d, t, la, sh, t2;
    acc = 0;
    for (int k = 0; k < M; k++) begin
      d   = s16(longint'(bv[k]) - longint'(rv[k]));
      t   = s16((d * longint'(fv[k])) >>> 15);
      la  = s32(2 * longint'(wv[k]) * t);
      sh  = s32(la * 16);
      t2  = sh >>> 16;
      acc = s32(acc + s32(2 * t2 * t));
    end
    return acc[31:0];
  endfunction

  task automatic clear_arrays();
    for (int k = 0; k < 16; k++) begin
      bv[k] = 0; rv[k] = 0; fv[k] = 0; wv[k] = 0;
    end
  endtask

  task automatic load();
    logic [15:0] v;
    for (int k = 0; k < 16; k++) begin
      v = bv[k][15:0];
      mem[{bB[10:4], 4'(k)}] = {16'hA5A5, v};
      v = rv[k][15:0];
      mem[{rB[10:4], 4'(k)}] = {16'h5A5A, v};
      v = fv[k][15:0];
      mem[{fB[10:4], 4'(k)}] = {16'hC3C3, v};
      v = wv[k][15:0];
      mem[{wB[10:4], 4'(k)}] = {16'h3C3C, v};
    end
    bus.bufAddr   = bB;
    bus.rbufAddr  = rB;
    bus.fgSumAddr = fB;
    bus.wegtAddr  = wB;
    bus.tdistAddr = tA;
  endtask

  task automatic run(input string name, input logic [31:0] exp,
                     input bit midStarts);
    int cyc;
    int doneCyc;
    logic [10:0] ea;
    logic [31:0] e;
    expQ.push_back(exp);
    for (int k = 0; k < M; k++) begin
      addrQ.push_back({bB[10:4], 4'(k)});
      addrQ.push_back({rB[10:4], 4'(k)});
      addrQ.push_back({fB[10:4], 4'(k)});
      addrQ.push_back({wB[10:4], 4'(k)});
      addrQ.push_back(11'h000);
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    doneCyc = 0;
    while (cyc <= 200 && doneCyc == 0) begin
      if (bus.done === 1'b1) begin
        doneCyc = cyc;
      end else begin
        ea = (addrQ.size() > 0) ? addrQ.pop_front() : 11'h000;
        checks++;
        if (bus.memReadAddr !== ea) begin
          errors++;
          $display("FAIL %s raddr cyc=%0d got=%h exp=%h",
                   name, cyc, bus.memReadAddr, ea);
        end
        checks++;
        if (bus.memWriteEn !== 1'b0) begin
          errors++;
          $display("FAIL %s early_we cyc=%0d got=%b exp=0",
                   name, cyc, bus.memWriteEn);
        end
        bus.start = midStarts && (cyc == 10 || cyc == 30);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc++;
      end
    end
    addrQ.delete();
    checks++;
    if (doneCyc != LAT) begin
      errors++;
      $display("FAIL %s latency got=%0d exp=%0d", name, doneCyc, LAT);
    end
    e = expQ.pop_front();
    if (doneCyc != 0) begin
      checks++;
      if (bus.L_tdist !== e) begin
        errors++;
        $display("FAIL %s L_tdist got=%h exp=%h", name, bus.L_tdist, e);
      end
`ifdef LSP_GET_TDIST_MEMWRITE_EN
      checks++;
      if (bus.memWriteEn !== 1'b1 || bus.memWriteAddr !== tA ||
          bus.memOut !== e) begin
        errors++;
        $display("FAIL %s write got=%b/%h/%h exp=1/%h/%h", name,
                 bus.memWriteEn, bus.memWriteAddr, bus.memOut, tA, e);
      end
`else
      checks++;
      if (bus.memWriteEn !== 1'b0) begin
        errors++;
        $display("FAIL %s done_we got=%b exp=0", name, bus.memWriteEn);
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.L_tdist !== e) begin
        errors++;
        $display("FAIL %s hold got=%b/%h exp=0/%h",
                 name, bus.done, bus.L_tdist, e);
      end
    end
  endtask

  task automatic no_done(input string name, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL %s extra_done got=%0d exp=0", name, seen);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.L_tdist !== 32'h0) begin
      errors++;
      $display("FAIL rst_ltdist got=%h exp=0", bus.L_tdist);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.memWriteEn !== 1'b0 || bus.memReadAddr !== 11'h0) begin
      errors++;
      $display("FAIL rst_mem got=%b/%h exp=0/0",
               bus.memWriteEn, bus.memReadAddr);
    end
    checks++;
    if (bus.memWriteAddr !== 11'h0 || bus.memOut !== 32'h0) begin
      errors++;
      $display("FAIL rst_wr got=%h/%h exp=0/0",
               bus.memWriteAddr, bus.memOut);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic set_case2();
    clear_arrays();
    for (int k = 0; k < M; k++) begin
      bv[k] = 100 * k - 321;
      rv[k] = bv[k];
      fv[k] = 12000;
      wv[k] = 3000;
    end
    bv[0] = 1000; rv[0] = 0; fv[0] = 32767; wv[0] = 2048;
  endtask

  task automatic test_zero();
    clear_arrays();
    load();
    run("zero", 32'h0, 1'b0);
  endtask

  task automatic test_single();
    set_case2();
    load();
    run("single", 32'd1996002, 1'b0);
  endtask

  task automatic test_saturate();
    clear_arrays();
    bv[0] = 32767; rv[0] = -32768; fv[0] = 32767; wv[0] = 32767;
    load();
    run("sat_one", 32'd2147287044, 1'b0);
    for (int k = 0; k < M; k++) begin
      bv[k] = 32767; rv[k] = -32768; fv[k] = 32767; wv[k] = 32767;
    end
    load();
    run("sat_all", 32'h7FFFFFFF, 1'b0);
  endtask

  task automatic test_addressing();
    bB = 11'h123; rB = 11'h237; fB = 11'h34F; wB = 11'h45A;
    set_case2();
    load();
    run("addr_ign", 32'd1996002, 1'b1);
    no_done("addr_ign", 60);
    bB = 11'h100; rB = 11'h200; fB = 11'h300; wB = 11'h400;
  endtask

  task automatic test_reset_mid();
    set_case2();
    load();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    checks++;
    if (bus.L_tdist !== 32'd1996002) begin
      errors++;
      $display("FAIL mid_partial got=%h exp=%h",
               bus.L_tdist, 32'd1996002);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (bus.L_tdist !== 32'h0 || bus.done !== 1'b0 ||
        bus.memReadAddr !== 11'h0) begin
      errors++;
      $display("FAIL mid_abort got=%h/%b/%h exp=0/0/0",
               bus.L_tdist, bus.done, bus.memReadAddr);
    end
    no_done("mid_abort", 60);
    run("mid_fresh", 32'd1996002, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      clear_arrays();
      for (int k = 0; k < M; k++) begin
        bv[k] = int'($urandom_range(8000)) - 4000;
        rv[k] = int'($urandom_range(8000)) - 4000;
        fv[k] = int'($urandom_range(32767));
        wv[k] = int'($urandom_range(4000));
      end
      load();
      run("random", model(), 1'b0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    for (int a = 0; a < 2048; a++) mem[a] = 32'h0;
    clear_arrays();
    load();
    test_reset();
    test_zero();
    test_single();
    test_saturate();
    test_addressing();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
